// File: rtl/dmem_arb_pkg.sv
`default_nettype none
//==========================================================================
// dmem_arb_pkg : shared types and helpers for the data-RAM arbiter
// Rev 1.0
//==========================================================================
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_PEND = 1'b1
  } dmem_arb_state_e;

  localparam int MAX_NREQ = 8;

  // Index width for an n-entry vector; never zero so 1-entry vectors still index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
//==========================================================================
// rr_pick : picks the first set request at or after (i_ptr+1) mod NREQ
// Rev 1.0
//==========================================================================
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
//==========================================================================
// dmem_arbiter : shares one single-port sync RAM among NREQ requesters.
// DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority (index 0 wins).
// Rev 1.0
//==========================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rvalid,
  output logic [DW-1:0]        rdata,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int IW = idx_w(NREQ);
  localparam logic [0:0] S_IDLE    = IDLE;
  localparam logic [0:0] S_RD_PEND = RD_PEND;

  logic [0:0]    r_state;
  logic [IW-1:0] r_rd_owner;
  logic [IW-1:0] w_ptr;
  logic [IW-1:0] w_idx;
  logic          w_any;
  logic          w_rd_grant;

`ifdef DMEM_ARB_RR_EN
  logic [IW-1:0] r_last;

  always_ff @(posedge clk) begin
    if (reset)      r_last <= IW'(NREQ - 1);
    else if (w_any) r_last <= w_idx;
  end

  assign w_ptr = r_last;
`else
  // Pointer pinned to the top index makes the search start at requester 0.
  assign w_ptr = IW'(NREQ - 1);
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req),
    .i_ptr (w_ptr),
    .o_gnt (gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign mem_we     = w_any & req_we[w_idx];
  assign mem_addr   = w_any ? req_addr[int'(w_idx)*AW +: AW]  : '0;
  assign mem_wdata  = w_any ? req_wdata[int'(w_idx)*DW +: DW] : '0;
  assign w_rd_grant = w_any & ~req_we[w_idx];
  assign rdata      = mem_rdata;

  // Gated by reset so a read pending when reset hits never strobes.
  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rvalid[i] = (r_state == S_RD_PEND) && !reset && (r_rd_owner == IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rd_owner <= '0;
    end else if (w_rd_grant) begin
      r_state    <= S_RD_PEND;
      r_rd_owner <= w_idx;
    end else begin
      r_state    <= S_IDLE;
    end
  end

endmodule
`default_nettype wire
